lane_to_byte_demapping: RTL and testbench

LANE_TO_BYTE_DEMAPPING -- requirements
Module: lane_to_byte_demapping

---
 rtl/lane_to_byte_demapping_pkg.sv | 26 ++
 rtl/lane_to_byte_demapping_if.sv | 26 ++
 rtl/lane_to_byte_demapping_beat_select.sv | 43 ++++
 rtl/lane_to_byte_demapping.sv | 104 ++++++++++
 tb/tb_lane_to_byte_demapping.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_to_byte_demapping_pkg.sv
// Shared MB mapper definitions: lane-mode encodings, beat counts and FSM states.
// The transmit mapper uses the same encodings, so both sides agree on the frame layout.
package lane_to_byte_demapping_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,   // no functional lanes
    MODE_LO   = 2'b01,   // lanes 0-7
    MODE_HI   = 2'b10,   // lanes 8-15
    MODE_ALL  = 2'b11    // lanes 0-15
  } rx_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } demap_state_e;

  localparam int BEATS_HALF = 32;   // beats per frame with 8 active lanes
  localparam int BEATS_FULL = 16;   // beats per frame with 16 active lanes
  localparam int BEAT_CNT_W = $clog2(BEATS_HALF);

  // Index of the final beat of a frame for the given lane mode.
  function automatic logic [BEAT_CNT_W-1:0] last_beat(input rx_mode_e mode);
    return (mode == MODE_ALL) ? BEAT_CNT_W'(BEATS_FULL - 1) : BEAT_CNT_W'(BEATS_HALF - 1);
  endfunction

endpackage

// File: rtl/lane_to_byte_demapping_if.sv
// Receive lane bus into the demapper and the reassembled-frame outputs.
interface lane_to_byte_demapping_if #(
  parameter int WIDTH     = 32,
  parameter int N_BYTES   = 1024,
  parameter int NUM_LANES = 16
);

  logic [NUM_LANES-1:0][WIDTH-1:0] i_lane;
  logic                            i_lane_valid;
  logic [8*N_BYTES-1:0]            o_out_data;
  logic                            o_data_valid;
  logic                            o_busy;

  // Lane source side (PHY / testbench).
  modport master (
    output i_lane, i_lane_valid,
    input  o_out_data, o_data_valid, o_busy
  );

  // Demapper side.
  modport slave (
    input  i_lane, i_lane_valid,
    output o_out_data, o_data_valid, o_busy
  );

endinterface

// File: rtl/lane_to_byte_demapping_beat_select.sv
// lane_beat_select: picks the active lane words for the current mode and
// renumbers them so logical lane j always lands in slot j.
module lane_beat_select
  import lane_to_byte_demapping_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_LANES = 16
) (
  input  logic [NUM_LANES-1:0][WIDTH-1:0] lanes,
  input  rx_mode_e                        mode,
  output logic [NUM_LANES-1:0][WIDTH-1:0] sel,
  output logic [NUM_LANES-1:0]            sel_en
);

  localparam int HALF = NUM_LANES / 2;

  // Route the half or full lane set into the low slots and flag which slots carry data.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    sel    = '0;
    sel_en = '0;
    case (mode)
      MODE_LO: begin
        for (int j = 0; j < HALF; j++) begin
          sel[j]    = lanes[j];
          sel_en[j] = 1'b1;
        end
      end
      MODE_HI: begin
        for (int j = 0; j < HALF; j++) begin
          sel[j]    = lanes[HALF + j];
          sel_en[j] = 1'b1;
        end
      end
      MODE_ALL: begin
        sel    = lanes;
        sel_en = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lane_to_byte_demapping.sv
// Lane-to-byte demapper: collects lane beats into one frame of N_BYTES and
// presents it with a one-cycle valid pulse once the last beat has arrived.
module lane_to_byte_demapping
  import lane_to_byte_demapping_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N_BYTES   = 1024,
  parameter int NUM_LANES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      enable_demapper,
  input  logic [1:0]                i_functional_rx_lanes,
  lane_to_byte_demapping_if.slave   bus
);

  localparam int FRAME_W = 8 * N_BYTES;

  rx_mode_e                        mode;
  rx_mode_e                        frame_mode;
  demap_state_e                    state;
  logic [BEAT_CNT_W-1:0]           beat_cnt;
  logic [FRAME_W-1:0]              assembly;
  logic [FRAME_W-1:0]              asm_next;
  logic [FRAME_W-1:0]              out_data_q;
  logic                            data_valid_q;
  logic                            busy_q;
  logic [NUM_LANES-1:0][WIDTH-1:0] sel;
  logic [NUM_LANES-1:0]            sel_en;
  int                              lanes_per_beat;
  logic                            mode_change;
  logic                            accept;
  logic                            is_last;

  assign mode           = rx_mode_e'(i_functional_rx_lanes);
  assign lanes_per_beat = (mode == MODE_ALL) ? NUM_LANES : NUM_LANES / 2;
  // A mode different from the one the partial frame started under invalidates it.
  assign mode_change    = (state == ST_COLLECT) && (mode != frame_mode);
  assign accept         = enable_demapper && bus.i_lane_valid && (mode != MODE_NONE) && !mode_change;
  assign is_last        = accept && (beat_cnt == last_beat(mode));

  lane_beat_select #(
    .WIDTH     (WIDTH),
    .NUM_LANES (NUM_LANES)
  ) u_beat_select (
    .lanes  (bus.i_lane),
    .mode   (mode),
    .sel    (sel),
    .sel_en (sel_en)
  );

  // Assembly image with the current beat merged in at word k*L+j.
  always_comb begin
    asm_next = assembly;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (sel_en[j]) begin
        asm_next[(int'(beat_cnt) * lanes_per_beat + j) * WIDTH +: WIDTH] = sel[j];
      end
    end
  end

  // FSM, beat counter, assembly buffer and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      frame_mode   <= MODE_NONE;
      beat_cnt     <= '0;
      // NOTE: the wide assembly and output buffers are reset too, so a frame cut by reset can never leak out.
      assembly     <= '0;
      out_data_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; every register samples the pre-edge values.
      data_valid_q <= 1'b0;
      if (!enable_demapper || mode_change) begin
        state    <= ST_IDLE;
        beat_cnt <= '0;
        assembly <= '0;
        busy_q   <= 1'b0;
      end else if (accept) begin
        if (is_last) begin
          out_data_q   <= asm_next;
          data_valid_q <= 1'b1;
          state        <= ST_IDLE;
          beat_cnt     <= '0;
          assembly     <= '0;
          busy_q       <= 1'b0;
        end else begin
          assembly   <= asm_next;
          beat_cnt   <= beat_cnt + 1'b1;
          state      <= ST_COLLECT;
          frame_mode <= mode;
          busy_q     <= 1'b1;
        end
      end
    end
  end

  assign bus.o_out_data   = out_data_q;
  assign bus.o_data_valid = data_valid_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_lane_to_byte_demapping.sv
// Directed bench for lane_to_byte_demapping: a table of full frames per mode,
// then hand-written sequences for stall, mode switch, disable, reset and back-to-back frames.
module tb_lane_to_byte_demapping;
  import lane_to_byte_demapping_pkg::*;

  localparam int WIDTH     = 32;
  localparam int N_BYTES   = 1024;
  localparam int NUM_LANES = 16;
  localparam int FRAME_W   = 8 * N_BYTES;
  localparam int NUM_WORDS = FRAME_W / WIDTH;

  typedef enum {PAT_A5, PAT_CNT} pat_e;

  typedef struct {
    logic [1:0]  mode;
    pat_e        pat;
    logic [31:0] noise;       // value driven on inactive lanes
    int          exp_beats;   // hand-computed beats per frame
  } frame_vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       enable_demapper;
  logic [1:0] rx_mode;

  int total = 0;
  int bad   = 0;

  frame_vec_t vecs[5];

  lane_to_byte_demapping_if #(.WIDTH(WIDTH), .N_BYTES(N_BYTES), .NUM_LANES(NUM_LANES)) bus ();

  lane_to_byte_demapping #(.WIDTH(WIDTH), .N_BYTES(N_BYTES), .NUM_LANES(NUM_LANES)) dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .enable_demapper       (enable_demapper),
    .i_functional_rx_lanes (rx_mode),
    .bus                   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] gen(input pat_e pat, input int k, input int j, input int l);
    logic [7:0] kb;
    logic [7:0] jb;
    kb = k[7:0];
    jb = j[7:0];
    return (pat == PAT_A5) ? {kb, jb, 16'hA5A5} : 32'(k * l + j);
  endfunction

  // Expected frame: word n came from beat n/L, logical lane n%L.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] mode, input pat_e pat);
    logic [FRAME_W-1:0] f;
    int l;
    l = (mode == 2'b11) ? 16 : 8;
    f = '0;
    for (int n = 0; n < NUM_WORDS; n++) f[n*WIDTH +: WIDTH] = gen(pat, n / l, n % l, l);
    return f;
  endfunction

  function automatic int word_diffs(input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
    int nd;
    nd = 0;
    for (int n = 0; n < NUM_WORDS; n++) begin
      if (act[n*WIDTH +: WIDTH] !== exp[n*WIDTH +: WIDTH]) begin
        if (nd == 0) $display("  first differing word %0d: got %h expected %h",
                              n, act[n*WIDTH +: WIDTH], exp[n*WIDTH +: WIDTH]);
        nd++;
      end
    end
    return nd;
  endfunction

  // Drive beat k of the given mode; inactive lanes carry the noise word.
  task automatic set_beat(input logic [1:0] mode, input pat_e pat, input logic [31:0] noise, input int k);
    rx_mode          = mode;
    bus.i_lane_valid = 1'b1;
    for (int p = 0; p < NUM_LANES; p++) begin
      logic active;
      int   j;
      int   l;
      case (mode)
        2'b01:   begin active = (p < 8);  j = p;     l = 8;  end
        2'b10:   begin active = (p >= 8); j = p - 8; l = 8;  end
        2'b11:   begin active = 1'b1;     j = p;     l = 16; end
        default: begin active = 1'b0;     j = 0;     l = 8;  end
      endcase
      bus.i_lane[p] = active ? gen(pat, k, j, l) : noise;
    end
  endtask

  // Drive beats k0..k1 back to back; count valid pulses and report valid after the final beat.
  task automatic run_range(input logic [1:0] mode, input pat_e pat, input logic [31:0] noise,
                           input int k0, input int k1, output int pulses, output logic last_valid);
    pulses     = 0;
    last_valid = 1'b0;
    for (int k = k0; k <= k1; k++) begin
      set_beat(mode, pat, noise, k);
      tick();
      if (bus.o_data_valid) pulses++;
      last_valid = bus.o_data_valid;
    end
    bus.i_lane_valid = 1'b0;
  endtask

  // Feed beats until the valid pulse appears, within a cycle budget.
  task automatic run_frame(input logic [1:0] mode, input pat_e pat, input logic [31:0] noise,
                           output int nbeats, output int busy_err, output logic seen);
    nbeats   = 0;
    busy_err = 0;
    seen     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      set_beat(mode, pat, noise, k);
      tick();
      nbeats++;
      if (bus.o_data_valid) begin
        seen = 1'b1;
        break;
      end
      if (!bus.o_busy) busy_err++;
    end
    bus.i_lane_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nbeats;
    int   busy_err;
    int   pulses;
    int   errs;
    int   hits;
    logic seen;
    logic lv;

    vecs[0] = '{2'b11, PAT_A5,  32'h0000_0000, 16};
    vecs[1] = '{2'b01, PAT_CNT, 32'hFFFF_FFFF, 32};
    vecs[2] = '{2'b10, PAT_CNT, 32'hDEAD_BEEF, 32};
    vecs[3] = '{2'b11, PAT_CNT, 32'h0000_0000, 16};
    vecs[4] = '{2'b01, PAT_A5,  32'h1234_5678, 32};

    i_rst_n          = 1'b0;
    enable_demapper  = 1'b1;
    rx_mode          = 2'b00;
    bus.i_lane_valid = 1'b0;
    bus.i_lane       = '0;
    repeat (3) @(negedge i_clk);
    check("reset out_data", 64'(word_diffs(bus.o_out_data, '0)), 0);
    check("reset data_valid", bus.o_data_valid, 0);
    check("reset busy", bus.o_busy, 0);
    i_rst_n = 1'b1;
    tick();

    // Full frames from the vector table.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].mode, vecs[i].pat, vecs[i].noise, nbeats, busy_err, seen);
      check($sformatf("vec%0d pulse seen", i), seen, 1);
      check($sformatf("vec%0d beats", i), nbeats, vecs[i].exp_beats);
      check($sformatf("vec%0d busy during frame", i), busy_err, 0);
      check($sformatf("vec%0d busy after frame", i), bus.o_busy, 0);
      check($sformatf("vec%0d data", i),
            64'(word_diffs(bus.o_out_data, build_frame(vecs[i].mode, vecs[i].pat))), 0);
      if (vecs[i].noise != 32'h0) begin
        hits = 0;
        for (int n = 0; n < NUM_WORDS; n++)
          if (bus.o_out_data[n*WIDTH +: WIDTH] == vecs[i].noise) hits++;
        check($sformatf("vec%0d inactive lanes ignored", i), hits, 0);
      end
      tick();
      check($sformatf("vec%0d pulse one cycle", i), bus.o_data_valid, 0);
      check($sformatf("vec%0d data held", i),
            64'(word_diffs(bus.o_out_data, build_frame(vecs[i].mode, vecs[i].pat))), 0);
    end

    // Stall: lane_valid low for 3 cycles after beat 5 of a mode-11 frame.
    run_range(2'b11, PAT_A5, 32'h0, 0, 5, pulses, lv);
    check("stall no early pulse", pulses, 0);
    errs = 0;
    repeat (3) begin
      tick();
      if (!bus.o_busy || bus.o_data_valid) errs++;
    end
    check("stall busy held", errs, 0);
    run_range(2'b11, PAT_A5, 32'h0, 6, 15, pulses, lv);
    check("stall pulse count", pulses, 1);
    check("stall pulse after beat 15", lv, 1);
    check("stall data", 64'(word_diffs(bus.o_out_data, build_frame(2'b11, PAT_A5))), 0);
    tick();

    // Mode switch 01 -> 11 after beat 10: partial frame dropped, switch beat ignored.
    run_range(2'b01, PAT_CNT, 32'h0, 0, 10, pulses, lv);
    check("switch partial no pulse", pulses, 0);
    set_beat(2'b11, PAT_CNT, 32'h0, 0);
    tick();
    bus.i_lane_valid = 1'b0;
    check("switch busy cleared", bus.o_busy, 0);
    check("switch no pulse", bus.o_data_valid, 0);
    run_range(2'b11, PAT_CNT, 32'h0, 0, 14, pulses, lv);
    check("switch no pulse before beat 15", pulses, 0);
    check("switch prior data held", 64'(word_diffs(bus.o_out_data, build_frame(2'b11, PAT_A5))), 0);
    run_range(2'b11, PAT_CNT, 32'h0, 15, 15, pulses, lv);
    check("switch pulse after beat 15", lv, 1);
    check("switch new frame", 64'(word_diffs(bus.o_out_data, build_frame(2'b11, PAT_CNT))), 0);
    tick();

    // Disable mid-frame: collection cleared, output held.
    run_range(2'b11, PAT_A5, 32'h0, 0, 3, pulses, lv);
    set_beat(2'b11, PAT_A5, 32'h0, 4);
    enable_demapper = 1'b0;
    tick();
    check("disable busy cleared", bus.o_busy, 0);
    check("disable no pulse", bus.o_data_valid, 0);
    check("disable data held", 64'(word_diffs(bus.o_out_data, build_frame(2'b11, PAT_CNT))), 0);
    enable_demapper = 1'b1;
    run_range(2'b11, PAT_A5, 32'h0, 0, 15, pulses, lv);
    check("after disable pulse count", pulses, 1);
    check("after disable frame", 64'(word_diffs(bus.o_out_data, build_frame(2'b11, PAT_A5))), 0);
    tick();

    // Mode 00 entered from COLLECT acts as a mode change and accepts nothing.
    run_range(2'b01, PAT_CNT, 32'h0, 0, 4, pulses, lv);
    set_beat(2'b00, PAT_CNT, 32'h5555_5555, 5);
    tick();
    check("mode00 abort busy", bus.o_busy, 0);
    tick();
    check("mode00 no accept busy", bus.o_busy, 0);
    bus.i_lane_valid = 1'b0;
    run_range(2'b01, PAT_CNT, 32'h0, 0, 31, pulses, lv);
    check("mode00 next frame pulse", lv, 1);
    check("mode00 next frame data", 64'(word_diffs(bus.o_out_data, build_frame(2'b01, PAT_CNT))), 0);
    tick();

    // Reset after beat 7: everything cleared, fresh frame reassembled from scratch.
    run_range(2'b11, PAT_A5, 32'h0, 0, 7, pulses, lv);
    i_rst_n = 1'b0;
    #1;
    check("midreset out_data cleared", 64'(word_diffs(bus.o_out_data, '0)), 0);
    check("midreset busy", bus.o_busy, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_range(2'b11, PAT_CNT, 32'h0, 0, 14, pulses, lv);
    check("postreset no early pulse", pulses, 0);
    check("postreset out_data zero", 64'(word_diffs(bus.o_out_data, '0)), 0);
    run_range(2'b11, PAT_CNT, 32'h0, 15, 15, pulses, lv);
    check("postreset pulse", lv, 1);
    check("postreset frame", 64'(word_diffs(bus.o_out_data, build_frame(2'b11, PAT_CNT))), 0);

    // Back-to-back: first beat of the next frame right after the last beat.
    run_range(2'b01, PAT_CNT, 32'h0, 0, 31, pulses, lv);
    check("b2b frame A pulse", lv, 1);
    check("b2b frame A data", 64'(word_diffs(bus.o_out_data, build_frame(2'b01, PAT_CNT))), 0);
    run_range(2'b11, PAT_A5, 32'h0, 0, 0, pulses, lv);
    check("b2b first beat accepted", bus.o_busy, 1);
    check("b2b pulse single", bus.o_data_valid, 0);
    run_range(2'b11, PAT_A5, 32'h0, 1, 15, pulses, lv);
    check("b2b frame B pulse", lv, 1);
    check("b2b frame B data", 64'(word_diffs(bus.o_out_data, build_frame(2'b11, PAT_A5))), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
